// File: rtl/psone_key_scan.sv
// Debounced key scanner: per-key synchronizer and tick-based debounce, with
// press/release events queued per key and issued round-robin over a valid/ready port.
module psone_key_scan #(
    parameter int KEYS  = 8,
    parameter int PRESC = 27000,
    parameter int DEB   = 20
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic [KEYS-1:0]         iKEY,
    input  logic                    iREADY,
    output logic [KEYS-1:0]         oKEYS,
    output logic                    oVALID,
    output logic [$clog2(KEYS)-1:0] oEVT_KEY,
    output logic                    oEVT_PRESS,
    output logic                    oOVF,
    output logic                    oTICK
);
    localparam int KW = $clog2(KEYS);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int CW = $clog2(DEB + 1);

    logic [KEYS-1:0] sync1, s;
    logic [PW-1:0]   pcount;
    logic [CW-1:0]   cnt [KEYS];
    logic [KEYS-1:0] commit, commit_q;
    logic [KEYS-1:0] pend, ptype;
    logic [KEYS-1:0] gvec;
    logic [KW-1:0]   ptr, grant;
    logic            grant_ok, free, take;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= iKEY;
            s     <= sync1;
        end
    end

    assign oTICK = (pcount == PW'(PRESC - 1));

    always_ff @(posedge iCLK) begin
        if (iRESET || oTICK) pcount <= '0;
        else                 pcount <= pcount + 1'b1;
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        commit = '0;
        for (int i = 0; i < KEYS; i++)
            commit[i] = (s[i] != oKEYS[i]) && oTICK && (cnt[i] == CW'(DEB - 1));
    end

    // NOTE: the counter array is small and must restart from zero, so it is reset like any other flop.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oKEYS    <= '0;
            commit_q <= '0;
            for (int i = 0; i < KEYS; i++) cnt[i] <= '0;
        end else begin
            commit_q <= commit;
            for (int i = 0; i < KEYS; i++) begin
                if (s[i] == oKEYS[i]) begin
                    cnt[i] <= '0;
                end else if (commit[i]) begin
                    oKEYS[i] <= s[i];
                    cnt[i]   <= '0;
                end else if (oTICK) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search: lowest offset from ptr wins, so scan offsets downward.
    always_comb begin
        logic [KW-1:0] idx;
        idx      = '0;
        grant    = '0;
        grant_ok = 1'b0;
        for (int j = KEYS - 1; j >= 0; j--) begin
            idx = ptr + KW'(j);
            if (pend[idx]) begin
                grant_ok = 1'b1;
                grant    = idx;
            end
        end
    end

    assign free = !oVALID || iREADY;
    assign take = free && grant_ok;
    assign gvec = take ? (KEYS'(1) << grant) : '0;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            pend       <= '0;
            ptype      <= '0;
            ptr        <= '0;
            oVALID     <= 1'b0;
            oEVT_KEY   <= '0;
            oEVT_PRESS <= 1'b0;
            oOVF       <= 1'b0;
        end else begin
            if (take) begin
                oVALID     <= 1'b1;
                oEVT_KEY   <= grant;
                oEVT_PRESS <= ptype[grant];
                ptr        <= grant + 1'b1;
            end else if (free) begin
                oVALID <= 1'b0;
            end
            // A fresh commit outranks a grant on the same key: the new event stays pending.
            for (int i = 0; i < KEYS; i++) begin
                if (commit_q[i]) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= oKEYS[i];
                end else if (gvec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (|(commit_q & pend & ~gvec)) oOVF <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psone_key_scan.sv
// Directed bench for psone_key_scan with KEYS=8, PRESC=4, DEB=3.
module tb_psone_key_scan;
    logic       iCLK = 1'b0;
    logic       iRESET;
    logic [7:0] iKEY;
    logic       iREADY;
    logic [7:0] oKEYS;
    logic       oVALID;
    logic [2:0] oEVT_KEY;
    logic       oEVT_PRESS;
    logic       oOVF;
    logic       oTICK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [3:0] evq [$];
    int         evt [$];

    psone_key_scan #(.KEYS(8), .PRESC(4), .DEB(3)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iKEY(iKEY), .iREADY(iREADY),
        .oKEYS(oKEYS), .oVALID(oVALID), .oEVT_KEY(oEVT_KEY),
        .oEVT_PRESS(oEVT_PRESS), .oOVF(oOVF), .oTICK(oTICK)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc++;

    // Record each accepted event as {press, key} with its cycle stamp.
    always @(negedge iCLK) begin
        if (!iRESET && oVALID && iREADY) begin
            evq.push_back({oEVT_PRESS, oEVT_KEY});
            evt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRESET = 1'b1;
        repeat (2) step();
        iRESET = 1'b0;
    endtask

    task automatic wait_keys(input string tag, input logic [7:0] exp);
        int n = 0;
        while (oKEYS !== exp && n < 40) begin
            step();
            n++;
        end
        check(tag, oKEYS, exp);
    endtask

    function automatic logic [3:0] pop_ev();
        if (evq.size() == 0) return 4'hF;
        void'(evt.pop_front());
        return evq.pop_front();
    endfunction

    initial begin
        int n;
        int t0, t1;
        iKEY   = '0;
        iREADY = 1'b1;
        do_reset();

        // Reset state and prescaler cadence
        check("rst_keys", oKEYS, 8'h00);
        check("rst_valid", oVALID, 1'b0);
        check("rst_evt_key", oEVT_KEY, 3'd0);
        check("rst_evt_press", oEVT_PRESS, 1'b0);
        check("rst_ovf", oOVF, 1'b0);
        check("tick_0", oTICK, 1'b0);
        for (int k = 1; k < 12; k++) begin
            step();
            check($sformatf("tick_%0d", k), oTICK, (k % 4) == 3);
        end

        // Single press on key 2: delay window and one event
        evq.delete(); evt.delete();
        iKEY[2] = 1'b1;
        n = 0;
        while (oKEYS[2] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("press2_delay_in_window", (n >= 11) && (n <= 14), 1'b1);
        check("press2_keys", oKEYS, 8'h04);
        repeat (5) step();
        check("press2_event_count", evq.size(), 1);
        check("press2_event", pop_ev(), {1'b1, 3'd2});
        check("press2_valid_drop", oVALID, 1'b0);

        // Short glitch on key 5 must not commit
        evq.delete(); evt.delete();
        iKEY[5] = 1'b1;
        repeat (6) step();
        iKEY[5] = 1'b0;
        repeat (20) step();
        check("glitch5_keys", oKEYS, 8'h04);
        check("glitch5_no_event", evq.size(), 0);

        iKEY = '0;
        wait_keys("release2_keys", 8'h00);
        repeat (5) step();
        check("release2_event", pop_ev(), {1'b0, 3'd2});

        // Simultaneous keys 0 and 7 from ptr=0
        do_reset();
        evq.delete(); evt.delete();
        iKEY = 8'h81;
        wait_keys("dual_keys", 8'h81);
        repeat (5) step();
        check("dual_event_count", evq.size(), 2);
        t0 = (evt.size() > 0) ? evt[0] : -10;
        t1 = (evt.size() > 1) ? evt[1] : 10;
        check("dual_back_to_back", t1 - t0, 1);
        check("dual_first", pop_ev(), {1'b1, 3'd0});
        check("dual_second", pop_ev(), {1'b1, 3'd7});
        check("dual_ptr", dut.ptr, 3'd0);
        iKEY = '0;
        wait_keys("dual_release", 8'h00);
        repeat (6) step();

        // Overwrite of a pending key-3 press by its release
        do_reset();
        evq.delete(); evt.delete();
        iREADY = 1'b0;
        iKEY = 8'h02;
        wait_keys("ovf_key1", 8'h02);
        repeat (3) step();
        check("ovf_slot_valid", oVALID, 1'b1);
        check("ovf_slot_key", oEVT_KEY, 3'd1);
        iKEY = 8'h0A;
        wait_keys("ovf_key3_press", 8'h0A);
        repeat (2) step();
        check("ovf_not_yet", oOVF, 1'b0);
        iKEY = 8'h02;
        wait_keys("ovf_key3_release", 8'h02);
        repeat (2) step();
        check("ovf_set", oOVF, 1'b1);
        iREADY = 1'b1;
        repeat (4) step();
        check("ovf_event_count", evq.size(), 2);
        check("ovf_ev_first", pop_ev(), {1'b1, 3'd1});
        check("ovf_ev_second", pop_ev(), {1'b0, 3'd3});
        check("ovf_sticky", oOVF, 1'b1);

        // Stall stability, then reset mid-handshake with a pending event
        iREADY = 1'b0;
        iKEY = 8'h00;
        wait_keys("stall_release1", 8'h00);
        repeat (3) step();
        iKEY = 8'h10;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("stall_valid_%0d", k), oVALID, 1'b1);
            check($sformatf("stall_key_%0d", k), oEVT_KEY, 3'd1);
            check($sformatf("stall_press_%0d", k), oEVT_PRESS, 1'b0);
            step();
        end
        iKEY   = 8'h00;
        iRESET = 1'b1;
        step();
        iRESET = 1'b0;
        check("mid_rst_keys", oKEYS, 8'h00);
        check("mid_rst_valid", oVALID, 1'b0);
        check("mid_rst_evt_key", oEVT_KEY, 3'd0);
        check("mid_rst_evt_press", oEVT_PRESS, 1'b0);
        check("mid_rst_ovf", oOVF, 1'b0);
        evq.delete(); evt.delete();
        iREADY = 1'b1;
        repeat (30) step();
        check("mid_rst_no_stale", evq.size(), 0);
        check("mid_rst_valid_after", oVALID, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
